moving_average_filter: RTL and testbench

Parametrised, multi-channel moving-average (boxcar) low-pass filter for the audio CODEC datapath. It sits between `readdata_*` and `writedata_*`. It accepts one sample per channel per `in_valid` strobe, keeps a running sum over the last 2^LOG2_TAPS samples, and emits the signed average one cycle later. It replaces the fixed 8-tap, pre-shifted, stereo-duplicated filter with a single instance that has a correct running sum and no free-running sub-blocks. It adds a bypass mode and a priming flag.

---
 rtl/moving_average_filter_if.sv | 23 ++
 rtl/moving_average_filter.sv | 76 +++++++
 tb/tb_moving_average_filter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/moving_average_filter_if.sv
// Sample stream into and filtered stream out of the moving-average filter.
// The source side drives samples and bypass; the filter drives the results.
interface moving_average_filter_if #(
  parameter int DATA_W   = 24,
  parameter int CHANNELS = 2
);
  logic                         in_valid;
  logic [CHANNELS*DATA_W-1:0]   in_data;
  logic                         bypass;
  logic                         out_valid;
  logic [CHANNELS*DATA_W-1:0]   out_data;
  logic                         primed;

  modport master (
    output in_valid, in_data, bypass,
    input  out_valid, out_data, primed
  );

  modport slave (
    input  in_valid, in_data, bypass,
    output out_valid, out_data, primed
  );
endinterface

// File: rtl/moving_average_filter.sv
// Multi-channel boxcar filter over the last 2^LOG2_TAPS samples.
// Each channel has its own running sum; the output is registered one cycle after accept.
module moving_average_filter #(
  parameter int DATA_W    = 24,
  parameter int LOG2_TAPS = 3,
  parameter int CHANNELS  = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  moving_average_filter_if.slave  bus
);
  localparam int N     = 1 << LOG2_TAPS;
  localparam int ACC_W = DATA_W + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0]   FILL_MAX = (LOG2_TAPS + 1)'(N);
  localparam logic [LOG2_TAPS:0]   FILL_ONE = (LOG2_TAPS + 1)'(1);
  localparam logic [LOG2_TAPS-1:0] PTR_ONE  = LOG2_TAPS'(1);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  sample_t                    hist_q [CHANNELS][N];
  sample_t                    x      [CHANNELS];
  acc_t                       acc_q  [CHANNELS];
  acc_t                       acc_d  [CHANNELS];
  logic [LOG2_TAPS-1:0]       wr_ptr_q;
  logic [LOG2_TAPS:0]         fill_q, fill_d;
  logic [CHANNELS*DATA_W-1:0] out_data_q, out_data_d;
  logic                       out_valid_q;
  logic                       primed_q;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
    out_data_d = out_data_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      x[ch]     = sample_t'(bus.in_data[ch*DATA_W +: DATA_W]);
      // Sum of exactly N in-range samples always fits ACC_W bits, so wrap in the
      // intermediate add is harmless.
      acc_d[ch] = acc_q[ch] + acc_t'(x[ch]) - acc_t'(hist_q[ch][wr_ptr_q]);
      out_data_d[ch*DATA_W +: DATA_W] =
        bus.bypass ? x[ch] : DATA_W'(acc_d[ch] >>> LOG2_TAPS);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // NOTE: the history buffer is reset because empty slots must read as zero while priming.
      for (int ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch] <= '0;
        for (int i = 0; i < N; i++) hist_q[ch][i] <= '0;
      end
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          acc_q[ch]            <= acc_d[ch];
          hist_q[ch][wr_ptr_q] <= x[ch];
        end
        wr_ptr_q   <= wr_ptr_q + PTR_ONE;
        fill_q     <= fill_d;
        out_data_q <= out_data_d;
        primed_q   <= (fill_q + FILL_ONE >= FILL_MAX);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.primed    = primed_q;
endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: a window-of-samples reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_moving_average_filter;
  localparam int DW = 24;
  localparam int L  = 3;
  localparam int N  = 1 << L;
  localparam int CH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  moving_average_filter_if #(.DATA_W(DW), .CHANNELS(CH)) bus ();

  moving_average_filter #(.DATA_W(DW), .LOG2_TAPS(L), .CHANNELS(CH)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the last N accepted samples per channel, averaged with floor division.
  longint          win [CH][$];
  int              accepted;
  logic [CH*DW-1:0] m_data;
  logic            m_valid;
  logic            m_primed;
  bit              live = 1'b0;
  longint          m_x, m_sum, m_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < CH; ch++) win[ch].delete();
      accepted = 0;
      m_data   = '0;
      m_valid  = 1'b0;
      m_primed = 1'b0;
      live     = 1'b1;
    end else if (live) begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        accepted++;
        for (int ch = 0; ch < CH; ch++) begin
          m_x = longint'($signed(bus.in_data[ch*DW +: DW]));
          win[ch].push_back(m_x);
          if (win[ch].size() > N) void'(win[ch].pop_front());
          m_sum = 0;
          foreach (win[ch][i]) m_sum += win[ch][i];
          m_q = m_sum / N;
          if ((m_sum % N) != 0 && m_sum < 0) m_q = m_q - 1;
          m_data[ch*DW +: DW] = bus.bypass ? DW'(m_x) : DW'(m_q);
        end
        m_primed = (accepted >= N);
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("cmp_out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("cmp_primed",    64'(bus.primed),    64'(m_primed));
      check("cmp_out_data",  64'(bus.out_data),  64'(m_data));
    end
  end

  task automatic put(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic byp = 1'b0);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {d1, d0};
    bus.bypass   = byp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.bypass   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [CH*DW-1:0] exp_data,
                     input logic exp_valid, input logic exp_primed);
    check({name, "_data"},   64'(bus.out_data),  64'(exp_data));
    check({name, "_valid"},  64'(bus.out_valid), 64'(exp_valid));
    check({name, "_primed"}, 64'(bus.primed),    64'(exp_primed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.bypass   = 1'b0;
    @(posedge clk);
    #1;
    lit("reset_state", '0, 1'b0, 1'b0);

    // Step of 0x800: ramps by 0x100 per accept, primed on the 8th.
    do_reset();
    for (int k = 0; k < N; k++) begin
      put(24'h000800, 24'h000800);
      lit("step", {2{DW'(256 * (k + 1))}}, 1'b1, k == N - 1);
    end
    idle(1);
    lit("step_hold", {2{24'h000800}}, 1'b0, 1'b1);

    // Constant -8: floor average goes -1 .. -8.
    do_reset();
    for (int k = 0; k < N; k++) begin
      put(24'hFFFFF8, 24'hFFFFF8);
      lit("neg", {2{DW'(-(k + 1))}}, 1'b1, k == N - 1);
    end

    // Impulse of -1 stays -1 for N outputs, then 0.
    do_reset();
    put(24'hFFFFFF, 24'hFFFFFF);
    lit("impulse_0", {2{24'hFFFFFF}}, 1'b1, 1'b0);
    for (int k = 1; k < N; k++) begin
      put('0, '0);
      lit("impulse_tail", {2{24'hFFFFFF}}, 1'b1, k == N - 1);
    end
    put('0, '0);
    lit("impulse_gone", '0, 1'b1, 1'b1);

    // Full-scale opposite extremes on the two channels.
    do_reset();
    for (int k = 0; k < N; k++) put(24'h7FFFFF, 24'h800000);
    lit("extremes", {24'h800000, 24'h7FFFFF}, 1'b1, 1'b1);

    // Prime with 800, then decay through the wrap-around.
    do_reset();
    for (int k = 0; k < N; k++) put(24'd800, 24'd800);
    lit("decay_full", {2{24'd800}}, 1'b1, 1'b1);
    for (int k = 1; k <= N; k++) begin
      put('0, '0);
      lit("decay", {2{DW'(800 - 100 * k)}}, 1'b1, 1'b1);
    end
    put('0, '0);
    lit("decay_ninth", '0, 1'b1, 1'b1);

    // Bypass passes the raw sample while still feeding the window; idles hold output.
    do_reset();
    for (int k = 0; k < N; k++) put(24'd800, 24'd800);
    put(24'd80, 24'd80, 1'b1);
    lit("bypass", {2{24'd80}}, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      lit("gap_hold", {2{24'd80}}, 1'b0, 1'b1);
    end
    put(24'd80, 24'd80, 1'b0);
    lit("bypass_release", {2{24'd620}}, 1'b1, 1'b1);

    // Reset coinciding with a valid input discards that input.
    do_reset();
    for (int k = 0; k < 10; k++) put(DW'(k * 1000 + 16), DW'(k * 333));
    check("mid_primed_before", 64'(bus.primed), 64'(1));
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = {24'h123456, 24'h654321};
    @(posedge clk);
    #1;
    lit("mid_reset", '0, 1'b0, 1'b0);
    put(24'h000800, 24'h000800);
    lit("after_reset", {2{24'h000100}}, 1'b1, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
